// File: rtl/mult_ctrl_taint.sv
`default_nettype none
// ============================================================================
// Module   : mult_ctrl_taint
// Purpose  : FSM controller for a taint-tracked shift-add sequential
//            multiplier. Sequences LOAD, then WIDTH ADD/SHIFT pairs, then
//            DONE. Every strobe and handshake output carries a taint shadow
//            bit so that information flowing through control decisions is
//            visible at the outputs.
// Ports    : clk, rst_n (synchronous, active-low)
//            start/start_t              - host request and its taint
//            multiplierReg/_t           - datapath multiplier readback + taint
//            mdld, mrld, rsclear        - load strobes (LOAD state)
//            rsload                     - add strobe (ADD state, data dependent)
//            rsshr                      - shift strobe (SHIFT state)
//            busy, done                 - host handshake
//            every output has a matching *_t taint output
// Options  : MULT_CTRL_ADD_SKIP_EN - when defined, ADD is skipped for a zero
//            multiplier bit (after the first iteration); a tainted bit at a
//            skip decision makes the session taint sticky until IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module mult_ctrl_taint #(
   parameter int WIDTH = 4                // operand width, >= 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             start_t,
   input  logic [WIDTH-1:0] multiplierReg,
   input  logic [WIDTH-1:0] multiplierReg_t,
   output logic             mdld,
   output logic             mdld_t,
   output logic             mrld,
   output logic             mrld_t,
   output logic             rsclear,
   output logic             rsclear_t,
   output logic             rsload,
   output logic             rsload_t,
   output logic             rsshr,
   output logic             rsshr_t,
   output logic             busy,
   output logic             busy_t,
   output logic             done,
   output logic             done_t
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_ADD   = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          ses_t_q, ses_t_d;   // session taint, applied to all outputs

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ses_t_d = ses_t_q;
      case (state_q)
         S_IDLE: begin
            // The decision to begin (or not) is itself influenced by start_t,
            // so the session taint tracks it every idle cycle.
            ses_t_d = start_t;
            if (start) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d   = '0;
            state_d = S_ADD;
         end
         S_ADD: begin
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
`ifdef MULT_CTRL_ADD_SKIP_EN
               // Branching on the next multiplier bit leaks its taint into
               // the timing of everything that follows.
               if (multiplierReg_t[cnt_d]) begin
                  ses_t_d = 1'b1;
               end
               state_d = multiplierReg[cnt_d] ? S_ADD : S_SHIFT;
`else
               state_d = S_ADD;
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ses_t_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ses_t_q <= ses_t_d;
      end
   end

   // ------------------------------------------------------------------------
   // Output decode (Moore, except rsload which reads the multiplier bit)
   // ------------------------------------------------------------------------
   always_comb begin
      mdld      = 1'b0;
      mdld_t    = 1'b0;
      mrld      = 1'b0;
      mrld_t    = 1'b0;
      rsclear   = 1'b0;
      rsclear_t = 1'b0;
      rsload    = 1'b0;
      rsload_t  = 1'b0;
      rsshr     = 1'b0;
      rsshr_t   = 1'b0;
      busy      = 1'b0;
      busy_t    = 1'b0;
      done      = 1'b0;
      done_t    = 1'b0;
      if (state_q != S_IDLE) begin
         busy   = 1'b1;
         busy_t = ses_t_q;
      end
      case (state_q)
         S_LOAD: begin
            mdld      = 1'b1;
            mdld_t    = ses_t_q;
            mrld      = 1'b1;
            mrld_t    = ses_t_q;
            rsclear   = 1'b1;
            rsclear_t = ses_t_q;
         end
         S_ADD: begin
            rsload   = multiplierReg[cnt_q];
            rsload_t = multiplierReg_t[cnt_q] | ses_t_q;
         end
         S_SHIFT: begin
            rsshr   = 1'b1;
            rsshr_t = ses_t_q;
         end
         S_DONE: begin
            done   = 1'b1;
            done_t = ses_t_q;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl_taint.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_ctrl_taint
// Purpose  : Self-checking bench for mult_ctrl_taint. A reference model holds
//            the planned sequence of steps of the current operation in a
//            queue; every cycle the DUT outputs are compared with what the
//            head step demands. Directed operations pin the model with
//            literal waveforms, then a randomized run follows.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mult_ctrl_taint;

   localparam int W = 4;
`ifdef MULT_CTRL_ADD_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   // output vector bit positions
   localparam int B_MDLD = 13, B_MDLD_T = 12, B_MRLD = 11, B_MRLD_T = 10;
   localparam int B_RSCLR = 9, B_RSCLR_T = 8, B_RSLD = 7, B_RSLD_T = 6;
   localparam int B_RSSHR = 5, B_RSSHR_T = 4, B_BUSY = 3, B_BUSY_T = 2;
   localparam int B_DONE = 1, B_DONE_T = 0;

   localparam int K_LOAD = 0, K_ADD = 1, K_SHIFT = 2, K_DONE = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start_t = 1'b0;
   logic [W-1:0] mr = '0;
   logic [W-1:0] mr_t = '0;
   logic mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t;
   logic rsshr, rsshr_t, busy, busy_t, done, done_t;

   mult_ctrl_taint #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
      .multiplierReg(mr), .multiplierReg_t(mr_t),
      .mdld(mdld), .mdld_t(mdld_t), .mrld(mrld), .mrld_t(mrld_t),
      .rsclear(rsclear), .rsclear_t(rsclear_t),
      .rsload(rsload), .rsload_t(rsload_t),
      .rsshr(rsshr), .rsshr_t(rsshr_t),
      .busy(busy), .busy_t(busy_t), .done(done), .done_t(done_t)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int kind;
      int idx;
      bit taint;   // this step's exit decision taints the session
   } step_t;

   step_t plan[$];
   bit    ses = 1'b0;
   bit    model_valid = 1'b0;
   logic [13:0] log_v [0:39];

   function automatic logic [13:0] dut_vec();
      return {mdld, mdld_t, mrld, mrld_t, rsclear, rsclear_t, rsload, rsload_t,
              rsshr, rsshr_t, busy, busy_t, done, done_t};
   endfunction

   function automatic logic [13:0] exp_vec();
      logic [13:0] e;
      step_t s;
      e = '0;
      if (plan.size() != 0) begin
         s = plan[0];
         e[B_BUSY]   = 1'b1;
         e[B_BUSY_T] = ses;
         case (s.kind)
            K_LOAD: begin
               e[B_MDLD] = 1'b1;  e[B_MDLD_T] = ses;
               e[B_MRLD] = 1'b1;  e[B_MRLD_T] = ses;
               e[B_RSCLR] = 1'b1; e[B_RSCLR_T] = ses;
            end
            K_ADD: begin
               e[B_RSLD]   = mr[s.idx];
               e[B_RSLD_T] = mr_t[s.idx] | ses;
            end
            K_SHIFT: begin
               e[B_RSSHR] = 1'b1; e[B_RSSHR_T] = ses;
            end
            default: begin
               e[B_DONE] = 1'b1;  e[B_DONE_T] = ses;
            end
         endcase
      end
      return e;
   endfunction

   task automatic build_plan();
      bit tb;
      plan.push_back('{K_LOAD, 0, 1'b0});
      for (int i = 0; i < W; i++) begin
         if (i == 0 || !SKIP || mr[i] == 1'b1)
            plan.push_back('{K_ADD, i, 1'b0});
         tb = (SKIP && i < W - 1) ? (mr_t[i+1] == 1'b1) : 1'b0;
         plan.push_back('{K_SHIFT, i, tb});
      end
      plan.push_back('{K_DONE, 0, 1'b0});
   endtask

   // advance the model across one rising edge using the inputs just sampled
   task automatic model_clock();
      step_t s;
      if (!rst_n) begin
         plan.delete();
         ses = 1'b0;
      end else if (plan.size() == 0) begin
         ses = start_t;
         if (start) build_plan();
      end else begin
         s = plan.pop_front();
         if (s.taint) ses = 1'b1;
      end
   endtask

   // one clock cycle: drive, compare, log, clock the model
   task automatic step(input logic r, input logic s, input logic st,
                       input logic [W-1:0] m, input logic [W-1:0] mt,
                       input int li);
      logic [13:0] got, expv;
      @(negedge clk);
      rst_n = r; start = s; start_t = st; mr = m; mr_t = mt;
      #1;
      if (model_valid) begin
         got  = dut_vec();
         expv = exp_vec();
         total++;
         if (got !== expv) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t got=%b exp=%b", $time, got, expv);
         end
      end
      if (li >= 0 && li < 40) log_v[li] = dut_vec();
      @(posedge clk);
      model_clock();
      model_valid = 1'b1;
   endtask

   function automatic logic [39:0] col(input int b, input int n);
      logic [39:0] c;
      c = '0;
      for (int k = 0; k < n; k++) c[k] = log_v[k][b];
      return c;
   endfunction

   function automatic logic [39:0] any_taint(input int n);
      logic [39:0] c;
      c = '0;
      for (int k = 0; k < n; k++) c[k] = |(log_v[k] & 14'b01010101010101);
      return c;
   endfunction

   task automatic pin(input string name, input logic [39:0] got, input logic [39:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, expv);
      end
   endtask

   // directed operation: start held for 'hold' cycles (start_t only in cycle 0),
   // optional one-cycle reset at cycle rst_at, n logged cycles, then drain
   task automatic run_op(input logic stt, input logic [W-1:0] m, input logic [W-1:0] mt,
                         input int hold, input int rst_at, input int n);
      int g;
      for (int k = 0; k < 40; k++) log_v[k] = '0;
      for (int k = 0; k < n; k++)
         step(k != rst_at, k < hold, (k == 0) ? stt : 1'b0, m, mt, k);
      g = 0;
      while (plan.size() != 0 && g < 64) begin
         step(1'b1, 1'b0, 1'b0, m, mt, -1);
         g++;
      end
      step(1'b1, 1'b0, 1'b0, m, mt, -1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] rm, rmt;
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, '0, '0, -1);
      for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 1'b0, '0, '0, -1);

`ifndef MULT_CTRL_ADD_SKIP_EN
      // normal multiply
      run_op(1'b0, 4'b1011, 4'b0000, 1, -1, 12);
      pin("a_rsload", col(B_RSLD, 12),  40'h114);
      pin("a_rsshr",  col(B_RSSHR, 12), 40'h2A8);
      pin("a_done",   col(B_DONE, 12),  40'h400);
      pin("a_busy",   col(B_BUSY, 12),  40'h7FE);
      pin("a_mdld",   col(B_MDLD, 12),  40'h002);
      pin("a_taints", any_taint(12),    40'h0);
      // tainted multiplier bit 2
      run_op(1'b0, 4'b1011, 4'b0100, 1, -1, 12);
      pin("b_rsload_t", col(B_RSLD_T, 12), 40'h040);
      pin("b_done",     col(B_DONE, 12),   40'h400);
      pin("b_done_t",   col(B_DONE_T, 12), 40'h0);
      // tainted start
      run_op(1'b1, 4'b1011, 4'b0000, 1, -1, 12);
      pin("c_mdld_t",    col(B_MDLD_T, 12),  40'h002);
      pin("c_mrld_t",    col(B_MRLD_T, 12),  40'h002);
      pin("c_rsclear_t", col(B_RSCLR_T, 12), 40'h002);
      pin("c_rsload_t",  col(B_RSLD_T, 12),  40'h154);
      pin("c_rsshr_t",   col(B_RSSHR_T, 12), 40'h2A8);
      pin("c_busy_t",    col(B_BUSY_T, 12),  40'h7FE);
      pin("c_done_t",    col(B_DONE_T, 12),  40'h400);
      run_op(1'b0, 4'b1011, 4'b0000, 1, -1, 12);
      pin("d_taints", any_taint(12), 40'h0);
      // reset mid-operation
      run_op(1'b0, 4'b1011, 4'b0000, 1, 5, 13);
      pin("e_busy", col(B_BUSY, 13), 40'h03E);
      pin("e_done", col(B_DONE, 13), 40'h0);
      pin("e_after_rst", col(B_BUSY, 13) | col(B_MDLD, 13) | col(B_RSSHR, 13)
                         | col(B_RSLD, 13) | any_taint(13), 40'h03E | 40'h002 | 40'h028 | 40'h014);
      run_op(1'b0, 4'b1011, 4'b0000, 1, -1, 12);
      pin("f_done", col(B_DONE, 12), 40'h400);
      // start held for 12 cycles
      run_op(1'b0, 4'b0110, 4'b0000, 12, -1, 14);
      pin("g_mdld", col(B_MDLD, 14), 40'h1002);
      pin("g_done", col(B_DONE, 14), 40'h400);
      pin("g_busy", col(B_BUSY, 14), 40'h37FE);
`else
      // zero-bit skipping with a tainted skip decision
      run_op(1'b0, 4'b0001, 4'b0010, 1, -1, 9);
      pin("h_rsload",  col(B_RSLD, 9),    40'h004);
      pin("h_rsshr",   col(B_RSSHR, 9),   40'h078);
      pin("h_rsshr_t", col(B_RSSHR_T, 9), 40'h070);
      pin("h_done",    col(B_DONE, 9),    40'h080);
      pin("h_done_t",  col(B_DONE_T, 9),  40'h080);
      pin("h_busy_t",  col(B_BUSY_T, 9),  40'h0F0);
`endif

      // randomized run
      rm = '0;
      rmt = '0;
      for (int c = 0; c < 3000; c++) begin
         if (plan.size() == 0 || !SKIP) begin
            rm  = W'($urandom);
            rmt = ($urandom_range(3) == 0) ? W'($urandom) : '0;
         end
         step($urandom_range(99) != 0, $urandom_range(3) == 0,
              1'($urandom_range(1)), rm, rmt, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mult_ctrl_taint.md
Name: mult_ctrl_taint

Overview:
- FSM controller for the taint-tracked shift-add sequential multiplier. It sits directly upstream of the multiplier datapath.
- Drives the datapath control strobes (mdld, mrld, rsclear, rsload, rsshr), each with a taint shadow bit.
- Reads back the multiplier register and its taint to decide each add.
- Provides a start/busy/done handshake to the host. Each handshake signal carries a taint bit, so information flow through control decisions is visible at the output.

Parameters:
WIDTH, 4, operand width; must be >= 2; the iteration counter is $clog2(WIDTH) bits wide.

Ports:
clk  input  1  clock (rising edge)
rst_n  input  1  synchronous active-low reset
start  input  1  request a multiply; sampled only in IDLE
start_t  input  1  taint of start
multiplierReg  input  WIDTH  multiplier register readback from datapath
multiplierReg_t  input  WIDTH  taint of multiplierReg
mdld  output  1  load multiplicand register
mdld_t  output  1  taint of mdld
mrld  output  1  load multiplier register
mrld_t  output  1  taint of mrld
rsclear  output  1  clear running sum
rsclear_t  output  1  taint of rsclear
rsload  output  1  add multiplicand into running sum
rsload_t  output  1  taint of rsload
rsshr  output  1  shift running sum right by 1
rsshr_t  output  1  taint of rsshr
busy  output  1  high in every state except IDLE
busy_t  output  1  taint of busy
done  output  1  one-cycle pulse, product valid
done_t  output  1  taint of done

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous, active-low, sampled on the rising edge of clk.
  - On reset: state=IDLE, cnt=0, session taint ses_t=0.
  - All strobes and their taints are 0; busy, busy_t, done and done_t are 0.
  - Reset mid-operation: FSM returns to IDLE at that edge; a partial product is abandoned with no done pulse.
- State encoding: IDLE, LOAD, ADD, SHIFT, DONE. All outputs are decoded from the registered state (Moore), except rsload, which also depends on multiplierReg.
- IDLE:
  - All strobes 0.
  - ses_t <= start_t every cycle. A tainted start taints the decision to begin, even if start=0.
  - start=1 -> LOAD.
- LOAD (1 cycle):
  - mdld=mrld=rsclear=1; each taint output = ses_t.
  - cnt <= 0; next state ADD.
- ADD (1 cycle):
  - rsload = multiplierReg[cnt]; rsload_t = multiplierReg_t[cnt] | ses_t.
  - Next state SHIFT.
- SHIFT (1 cycle):
  - rsshr=1; rsshr_t=ses_t.
  - If cnt==WIDTH-1 -> DONE; else cnt <= cnt+1 -> ADD.
- DONE (1 cycle):
  - done=1; done_t=ses_t.
  - Next state IDLE; ses_t is then reloaded from start_t.
- busy and busy_t:
  - busy=1 in LOAD, ADD, SHIFT and DONE.
  - busy_t = ses_t in those states; busy_t=0 in IDLE.
- Fixed latency: start high in cycle 0 -> LOAD in cycle 1 -> ADD/SHIFT pairs in cycles 2..2*WIDTH+1 -> done in cycle 2*WIDTH+2 (cycle 10 for WIDTH=4).
- Timing does not depend on data, so a tainted multiplier bit taints only the rsload_t of its own ADD cycle.
- start while busy: ignored and not queued. start_t while busy: ignored.
- At most one strobe group is active per cycle. rsload and rsshr are never asserted together; the datapath relies on this.

Optional Feature:
- Macro: MULT_CTRL_ADD_SKIP_EN.
- When defined:
  - On leaving SHIFT with cnt<WIDTH-1, the FSM examines multiplierReg[cnt+1]. If that bit is 0, it goes directly to SHIFT (skipping ADD) and increments cnt.
  - The first iteration, after LOAD, always visits ADD.
  - Each skip decision is control flow steered by data. If multiplierReg_t[cnt+1]=1 at that decision, ses_t <= 1 (sticky until IDLE).
  - From the next cycle onward, all taint outputs, including done_t and busy_t, are therefore high.
- When undefined: fixed-latency behaviour as above; ses_t depends only on start_t.

Test Plan:
- Normal multiply, WIDTH=4, all taints 0, multiplierReg=4'b1011 -> rsload in the four ADD cycles = 1,1,0,1; rsshr in cycles 3,5,7,9; done=1 in cycle 10 only; all _t outputs 0.
- Tainted multiplier bit: multiplierReg=4'b1011, multiplierReg_t=4'b0100 -> rsload_t=1 only in the third ADD cycle (cycle 6); done_t=0; done still in cycle 10.
- Tainted start: start=1, start_t=1 in cycle 0 -> mdld_t, mrld_t and rsclear_t =1 in cycle 1; every rsload_t/rsshr_t =1; busy_t=1 in cycles 1-10; done_t=1 in cycle 10. Next op with start_t=0 -> all taints 0.
- Reset mid-operation: rst_n=0 at cycle 5 -> from cycle 6 state is IDLE and all outputs are 0; no done pulse. A new start -> normal 10-cycle sequence.
- start held high for 12 cycles -> exactly one operation (done in cycle 10); a second LOAD begins only after IDLE is re-entered in cycle 11.
- (MULT_CTRL_ADD_SKIP_EN) multiplierReg=4'b0001, multiplierReg_t=4'b0010 -> sequence LOAD(1), ADD(2), SHIFT(3), SHIFT(4), SHIFT(5), SHIFT(6), DONE(7). rsshr_t=0 in cycle 3 and 1 in cycles 4-6; done_t=1.
